mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single memory port of the core: master 0 is instruction fetch, master 1 is load/store.
- Sits inside top between the core and the memory/peripheral bus (memory, LED register).
- Allows one outstanding transaction at a time, with selectable round-robin or fixed-priority arbitration.
- Has a response timeout so a dead slave cannot hang the core.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the core's single memory port.
// Master 0 is instruction fetch, master 1 is load/store. One transaction is in flight at a time.
// Arbitration is round-robin (FIXED_PRIO = 0) or fixed with master 1 winning ties (FIXED_PRIO = 1).
// A response timeout stops a dead slave from hanging the core.
//
// Ports:
//   clk_i, rstn_i            clock, synchronous active-low reset
//   mK_req_valid_i/ready_o   request handshake for master K
//   mK_addr/we/wdata/wstrb_i request fields for master K, sampled only at accept
//   mK_rsp_valid_o           one-cycle response pulse to the owning master
//   mK_rsp_err_o/rdata_o     timeout flag and read data, qualified by mK_rsp_valid_o
//   s_req_valid_o/ready_i    request handshake towards the slave
//   s_addr/we/wdata/wstrb_o  registered request fields
//   s_rsp_valid_i/rdata_i    slave response, one per accepted request
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  // Master 0 (instruction fetch)
  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic [3:0]        m0_wstrb_i,
  output logic              m0_rsp_valid_o,
  output logic              m0_rsp_err_o,
  output logic [31:0]       m0_rdata_o,
  // Master 1 (load/store)
  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [31:0]       m1_wdata_i,
  input  logic [3:0]        m1_wstrb_i,
  output logic              m1_rsp_valid_o,
  output logic              m1_rsp_err_o,
  output logic [31:0]       m1_rdata_o,
  // Slave side
  output logic              s_req_valid_o,
  input  logic              s_req_ready_i,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_we_o,
  output logic [31:0]       s_wdata_o,
  output logic [3:0]        s_wstrb_o,
  input  logic              s_rsp_valid_i,
  input  logic [31:0]       s_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  // Counter value on the last RSP cycle before the timeout fires.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e              state_q;
  logic                owner_q;
  logic                last_grant_q;
  logic [15:0]         cnt_q;
  logic                s_req_valid_q;
  logic [ADDR_W-1:0]   s_addr_q;
  logic                s_we_q;
  logic [31:0]         s_wdata_q;
  logic [3:0]          s_wstrb_q;

  logic                win;
  logic                grant;
  logic                timeout_hit;
  logic                rsp_fire;
  logic                rsp_err;
  logic [31:0]         rsp_rdata;

  // Winning master index; only meaningful while at least one request is valid.
  always_comb begin
    if (m0_req_valid_i && m1_req_valid_i) begin
      win = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
    end else begin
      win = m1_req_valid_i;
    end
  end

  // Gating with rstn_i keeps every handshake and pulse quiet while reset is applied.
  assign grant          = rstn_i && (state_q == StIdle) && (m0_req_valid_i || m1_req_valid_i);
  assign m0_req_ready_o = grant && !win;
  assign m1_req_ready_o = grant && win;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);
  // A real response in the expiry cycle takes precedence over the timeout.
  assign rsp_fire    = rstn_i && (state_q == StRsp) && (s_rsp_valid_i || timeout_hit);
  assign rsp_err     = !s_rsp_valid_i;
  assign rsp_rdata   = s_rsp_valid_i ? s_rdata_i : 32'h0;

  assign m0_rsp_valid_o = rsp_fire && !owner_q;
  assign m1_rsp_valid_o = rsp_fire && owner_q;
  assign m0_rsp_err_o   = rsp_err;
  assign m1_rsp_err_o   = rsp_err;
  assign m0_rdata_o     = rsp_rdata;
  assign m1_rdata_o     = rsp_rdata;

  assign s_req_valid_o = s_req_valid_q;
  assign s_addr_o      = s_addr_q;
  assign s_we_o        = s_we_q;
  assign s_wdata_o     = s_wdata_q;
  assign s_wstrb_o     = s_wstrb_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= 16'h0;
      s_req_valid_q <= 1'b0;
      s_addr_q      <= '0;
      s_we_q        <= 1'b0;
      s_wdata_q     <= 32'h0;
      s_wstrb_q     <= 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            owner_q       <= win;
            last_grant_q  <= win;
            s_req_valid_q <= 1'b1;
            s_addr_q      <= win ? m1_addr_i  : m0_addr_i;
            s_we_q        <= win ? m1_we_i    : m0_we_i;
            s_wdata_q     <= win ? m1_wdata_i : m0_wdata_i;
            s_wstrb_q     <= win ? m1_wstrb_i : m0_wstrb_i;
            state_q       <= StReq;
          end
        end
        StReq: begin
          if (s_req_ready_i) begin
            s_req_valid_q <= 1'b0;
            cnt_q         <= 16'h0;
            state_q       <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_fire) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share one stimulus stream.
// Each instance is checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int          TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          m0v, m1v, m0we, m1we, sready, srsp;
  logic [AW-1:0] m0addr, m1addr;
  logic [31:0]   m0wd, m1wd, srdata;
  logic [3:0]    m0st, m1st;

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic [1:0]    rdy0, rdy1, rv0, rv1, err0, err1, sv, swe;
  logic [31:0]   rd0 [2];
  logic [31:0]   rd1 [2];
  logic [AW-1:0] saddr [2];
  logic [31:0]   swd [2];
  logic [3:0]    sst [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(AW), .FIXED_PRIO(g), .TIMEOUT(TO)) u_dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .m0_req_valid_i (m0v),
      .m0_req_ready_o (rdy0[g]),
      .m0_addr_i      (m0addr),
      .m0_we_i        (m0we),
      .m0_wdata_i     (m0wd),
      .m0_wstrb_i     (m0st),
      .m0_rsp_valid_o (rv0[g]),
      .m0_rsp_err_o   (err0[g]),
      .m0_rdata_o     (rd0[g]),
      .m1_req_valid_i (m1v),
      .m1_req_ready_o (rdy1[g]),
      .m1_addr_i      (m1addr),
      .m1_we_i        (m1we),
      .m1_wdata_i     (m1wd),
      .m1_wstrb_i     (m1st),
      .m1_rsp_valid_o (rv1[g]),
      .m1_rsp_err_o   (err1[g]),
      .m1_rdata_o     (rd1[g]),
      .s_req_valid_o  (sv[g]),
      .s_req_ready_i  (sready),
      .s_addr_o       (saddr[g]),
      .s_we_o         (swe[g]),
      .s_wdata_o      (swd[g]),
      .s_wstrb_o      (sst[g]),
      .s_rsp_valid_i  (srsp),
      .s_rdata_i      (srdata)
    );
  end

  // Reference model: one pending transaction per instance, whether the slave took it,
  // and how many response cycles have gone by without an answer.
  logic          busy [2];
  logic          sent [2];
  logic          own [2];
  logic          last [2];
  int            waited [2];
  logic [AW-1:0] c_addr [2];
  logic          c_we [2];
  logic [31:0]   c_wd [2];
  logic [3:0]    c_st [2];
  int            w_m [2];
  logic          done_m [2];

  int n_cmp, n_err;
  int gq_rr [$];
  int gq_fp [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Go to the falling edge and compare every output against the model.
  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      string p;
      int    w;
      logic  e_r0, e_r1, e_sv, done;
      p = (i == 0) ? "rr" : "fp";
      if (m0v && !m1v)      w = 0;
      else if (m1v && !m0v) w = 1;
      else if (i == 1)      w = 1;
      else                  w = last[i] ? 0 : 1;
      e_r0 = rstn && !busy[i] && m0v && (w == 0);
      e_r1 = rstn && !busy[i] && m1v && (w == 1);
      e_sv = busy[i] && !sent[i];
      done = rstn && busy[i] && sent[i] && (srsp || (waited[i] == TO - 1));
      w_m[i]    = w;
      done_m[i] = done;
      check({p, " m0_ready"}, 32'(rdy0[i]), 32'(e_r0));
      check({p, " m1_ready"}, 32'(rdy1[i]), 32'(e_r1));
      check({p, " s_req_valid"}, 32'(sv[i]), 32'(e_sv));
      check({p, " m0_rsp_valid"}, 32'(rv0[i]), 32'(done && !own[i]));
      check({p, " m1_rsp_valid"}, 32'(rv1[i]), 32'(done && own[i]));
      if (e_sv) begin
        check({p, " s_addr"}, saddr[i], c_addr[i]);
        check({p, " s_we"}, 32'(swe[i]), 32'(c_we[i]));
        check({p, " s_wdata"}, swd[i], c_wd[i]);
        check({p, " s_wstrb"}, 32'(sst[i]), 32'(c_st[i]));
      end
      if (done && !own[i]) begin
        check({p, " m0_err"}, 32'(err0[i]), 32'(!srsp));
        check({p, " m0_rdata"}, rd0[i], srsp ? srdata : 32'h0);
      end
      if (done && own[i]) begin
        check({p, " m1_err"}, 32'(err1[i]), 32'(!srsp));
        check({p, " m1_rdata"}, rd1[i], srsp ? srdata : 32'h0);
      end
      if (rdy0[i]) begin
        if (i == 0) gq_rr.push_back(0);
        else        gq_fp.push_back(0);
      end
      if (rdy1[i]) begin
        if (i == 0) gq_rr.push_back(1);
        else        gq_fp.push_back(1);
      end
    end
  endtask

  // Apply the clock edge to the model, then move to just after the rising edge.
  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        busy[i] = 1'b0; sent[i] = 1'b0; last[i] = 1'b1; waited[i] = 0;
      end else if (!busy[i]) begin
        if (m0v || m1v) begin
          busy[i]   = 1'b1;
          sent[i]   = 1'b0;
          own[i]    = (w_m[i] == 1);
          last[i]   = (w_m[i] == 1);
          c_addr[i] = (w_m[i] == 1) ? m1addr : m0addr;
          c_we[i]   = (w_m[i] == 1) ? m1we   : m0we;
          c_wd[i]   = (w_m[i] == 1) ? m1wd   : m0wd;
          c_st[i]   = (w_m[i] == 1) ? m1st   : m0st;
        end
      end else if (!sent[i]) begin
        if (sready) begin
          sent[i] = 1'b1; waited[i] = 0;
        end
      end else if (done_m[i]) begin
        busy[i] = 1'b0;
      end else begin
        waited[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    rstn = 1'b1; m0v = 1'b0; m1v = 1'b0; m0we = 1'b0; m1we = 1'b0;
    m0addr = '0; m1addr = '0; m0wd = 32'h0; m1wd = 32'h0; m0st = 4'h0; m1st = 4'h0;
    sready = 1'b0; srsp = 1'b0; srdata = 32'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; sent[i] = 1'b0; own[i] = 1'b0; last[i] = 1'b1; waited[i] = 0;
      c_addr[i] = '0; c_we[i] = 1'b0; c_wd[i] = 32'h0; c_st[i] = 4'h0;
      w_m[i] = 0; done_m[i] = 1'b0;
    end
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    for (int k = 0; k < 2; k++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        check("rst s_addr", saddr[i], 32'h0);
        check("rst s_req_valid", 32'(sv[i]), 0);
      end
      advance();
    end
    rstn = 1'b1;
    step();
    step();

    // Single master read with zero-wait slave
    m0v = 1'b1; m0addr = 32'h100; m0we = 1'b0; sready = 1'b1;
    settle();
    for (int i = 0; i < 2; i++) check("rd c0 m0_ready", 32'(rdy0[i]), 1);
    advance();
    m0v = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      check("rd c1 s_req_valid", 32'(sv[i]), 1);
      check("rd c1 s_addr", saddr[i], 32'h100);
    end
    advance();
    srsp = 1'b1; srdata = 32'hDEADBEEF;
    settle();
    for (int i = 0; i < 2; i++) begin
      check("rd c2 m0_rsp_valid", 32'(rv0[i]), 1);
      check("rd c2 m0_rdata", rd0[i], 32'hDEADBEEF);
      check("rd c2 m0_err", 32'(err0[i]), 0);
      check("rd c2 m1_rsp_valid", 32'(rv1[i]), 0);
    end
    advance();
    srsp = 1'b0;
    step();

    // Continuous contention: rr alternates from master 0, fp always grants master 1
    do_reset();
    gq_rr.delete();
    gq_fp.delete();
    m0v = 1'b1; m1v = 1'b1; m0addr = 32'h1000; m1addr = 32'h2000;
    sready = 1'b1; srsp = 1'b1; srdata = 32'h12345678;
    repeat (12) step();
    m0v = 1'b0; m1v = 1'b0; srsp = 1'b0;
    check("rr grant count", gq_rr.size(), 4);
    check("fp grant count", gq_fp.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq_rr.size()) check($sformatf("rr grant %0d", k), gq_rr[k], k % 2);
      if (k < gq_fp.size()) check($sformatf("fp grant %0d", k), gq_fp[k], 1);
    end

    // Master 1 write with a stalled slave; fields change after accept
    m1v = 1'b1; m1we = 1'b1; m1addr = 32'h2000; m1wd = 32'h3F; m1st = 4'h1;
    sready = 1'b0; srsp = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) check("wr m1_ready", 32'(rdy1[i]), 1);
    advance();
    m1v = 1'b0; m1addr = '1; m1wd = 32'hFFFFFFFF; m1st = 4'hF; m1we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sready = (k == 5);
      settle();
      for (int i = 0; i < 2; i++) begin
        check("wr stall s_req_valid", 32'(sv[i]), 1);
        check("wr stall s_addr", saddr[i], 32'h2000);
        check("wr stall s_we", 32'(swe[i]), 1);
        check("wr stall s_wdata", swd[i], 32'h3F);
        check("wr stall s_wstrb", 32'(sst[i]), 1);
      end
      advance();
    end
    sready = 1'b0;
    step();
    srsp = 1'b1; srdata = 32'h0;
    settle();
    for (int i = 0; i < 2; i++) begin
      check("wr m1_rsp_valid", 32'(rv1[i]), 1);
      check("wr m1_err", 32'(err1[i]), 0);
      check("wr m0_rsp_valid", 32'(rv0[i]), 0);
    end
    advance();
    srsp = 1'b0;
    step();

    // Timeout on the 4th response cycle
    m0v = 1'b1; m0addr = 32'h300; m0we = 1'b0; sready = 1'b1; srsp = 1'b0;
    step();
    m0v = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("to cyc%0d m0_rsp_valid", k), 32'(rv0[i]), 32'(k == 3));
        if (k == 3) begin
          check("to m0_err", 32'(err0[i]), 1);
          check("to m0_rdata", rd0[i], 32'h0);
        end
      end
      advance();
    end
    step();

    // Response in the expiry cycle wins over the timeout
    m0v = 1'b1;
    step();
    m0v = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      srsp = (k == 3); srdata = 32'hCAFEF00D;
      settle();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("tor cyc%0d m0_rsp_valid", k), 32'(rv0[i]), 32'(k == 3));
        if (k == 3) begin
          check("tor m0_err", 32'(err0[i]), 0);
          check("tor m0_rdata", rd0[i], 32'hCAFEF00D);
        end
      end
      advance();
    end
    srsp = 1'b0;
    step();

    // Reset during RSP, late response afterwards, then a tie
    m0v = 1'b1; m0addr = 32'h400; sready = 1'b1; srsp = 1'b0;
    step();
    m0v = 1'b0;
    step();
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1; srsp = 1'b1; srdata = 32'hBAD0BAD0;
    settle();
    for (int i = 0; i < 2; i++) begin
      check("rstmid late m0_rsp_valid", 32'(rv0[i]), 0);
      check("rstmid late m1_rsp_valid", 32'(rv1[i]), 0);
    end
    advance();
    srsp = 1'b0; m0v = 1'b1; m1v = 1'b1;
    settle();
    check("rstmid rr m0_ready", 32'(rdy0[0]), 1);
    check("rstmid rr m1_ready", 32'(rdy1[0]), 0);
    check("rstmid fp m1_ready", 32'(rdy1[1]), 1);
    advance();
    m0v = 1'b0; m1v = 1'b0;
    repeat (6) step();

    // Randomized traffic, including stray responses and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rstn   = ($urandom_range(99) != 0);
      m0v    = ($urandom_range(9) < 6);
      m1v    = ($urandom_range(9) < 6);
      m0addr = $urandom;
      m1addr = $urandom;
      m0we   = 1'($urandom_range(1));
      m1we   = 1'($urandom_range(1));
      m0wd   = $urandom;
      m1wd   = $urandom;
      m0st   = 4'($urandom);
      m1st   = 4'($urandom);
      sready = ($urandom_range(9) < 7);
      srsp   = ($urandom_range(99) < 35);
      srdata = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
